display_driver: RTL and testbench

- Time-multiplexed driver for a 4-digit common-anode seven-segment display (Basys-style board).
- Takes four 4-bit hex digits with per-digit enables and scans one digit per scan_clk cycle.
- Drives shared active-low segment lines a–g and dp, plus active-low digit anodes an_3..an_0.
- Sits between the countdown/timer logic and the board pins; scan_clk is the already-divided scan clock.

---
 rtl/display_pkg.sv | 48 ++++
 rtl/seg7_decode.sv | 17 +
 rtl/display_driver.sv | 79 +++++++
 tb/tb_display_driver.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the 4-digit common-anode seven-segment driver.
// All segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
`default_nettype none

package display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = 2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  // Registered drive for the board pins.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } drive_t;

  localparam drive_t DRIVE_OFF = '{an: AN_OFF, seg: SEG_BLANK, dp: 1'b1};

  // Hex -> segment table; entry 0 is the rightmost (lowest) slice.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [3:0] anode_for(input logic [IDX_W-1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage : display_pkg

`default_nettype wire

// File: rtl/seg7_decode.sv
// Combinational 4-bit hex code to active-low seven-segment pattern {g..a}.
`default_nettype none

module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[code];
  end

endmodule : seg7_decode

`default_nettype wire

// File: rtl/display_driver.sv
// Time-multiplexed 4-digit seven-segment driver: one digit per scan_clk edge,
// scanning digit 0..3, with fully registered active-low segment and anode outputs.
`default_nettype none

module display_driver
  import display_pkg::*;
(
  input  logic       scan_clk,
  input  logic       rst,
  input  logic [3:0] digit_3,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_0,
  input  logic       enable_3,
  input  logic       enable_2,
  input  logic       enable_1,
  input  logic       enable_0,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp,
  output logic       an_3,
  output logic       an_2,
  output logic       an_1,
  output logic       an_0
);

  logic [IDX_W-1:0] idx;
  logic [3:0]       sel_digit;
  logic             sel_en;
  logic [6:0]       dec_seg;
  drive_t           drive_q;

  always_comb begin
    sel_digit = digit_0;
    sel_en    = enable_0;
    case (idx)
      2'd0: begin sel_digit = digit_0; sel_en = enable_0; end
      2'd1: begin sel_digit = digit_1; sel_en = enable_1; end
      2'd2: begin sel_digit = digit_2; sel_en = enable_2; end
      2'd3: begin sel_digit = digit_3; sel_en = enable_3; end
      default: begin sel_digit = digit_0; sel_en = enable_0; end
    endcase
  end

  seg7_decode u_decode (
    .code (sel_digit),
    .seg  (dec_seg)
  );

  // A disabled slot still consumes its cycle so the refresh period stays fixed.
  always_ff @(posedge scan_clk) begin
    if (rst) begin
      idx     <= '0;
      drive_q <= DRIVE_OFF;
    end else begin
      idx <= idx + 2'd1;
      if (sel_en) begin
        drive_q.an  <= anode_for(idx);
        drive_q.seg <= dec_seg;
      end else begin
        drive_q.an  <= AN_OFF;
        drive_q.seg <= SEG_BLANK;
      end
      drive_q.dp <= 1'b1;
    end
  end

  assign {g, f, e, d, c, b, a}    = drive_q.seg;
  assign dp                       = drive_q.dp;
  assign {an_3, an_2, an_1, an_0} = drive_q.an;

endmodule : display_driver

`default_nettype wire

// File: tb/tb_display_driver.sv
// Directed bench for display_driver with hand-computed segment/anode patterns.
`default_nettype none

module tb_display_driver;

  logic scan_clk = 1'b0;
  logic rst;
  logic [3:0] digit_3, digit_2, digit_1, digit_0;
  logic enable_3, enable_2, enable_1, enable_0;
  logic a, b, c, d, e, f, g, dp;
  logic an_3, an_2, an_1, an_0;

  int vectors     = 0;
  int miscompares = 0;

  // Expected active-low patterns {g,f,e,d,c,b,a}, worked out from the lit-segment list.
  logic [6:0] exp_tab [16];

  always #5 scan_clk = ~scan_clk;

  display_driver dut (
    .scan_clk (scan_clk),
    .rst      (rst),
    .digit_3  (digit_3),
    .digit_2  (digit_2),
    .digit_1  (digit_1),
    .digit_0  (digit_0),
    .enable_3 (enable_3),
    .enable_2 (enable_2),
    .enable_1 (enable_1),
    .enable_0 (enable_0),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .e        (e),
    .f        (f),
    .g        (g),
    .dp       (dp),
    .an_3     (an_3),
    .an_2     (an_2),
    .an_1     (an_1),
    .an_0     (an_0)
  );

  task automatic step();
    @(posedge scan_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    logic [3:0] obs_an;
    logic [6:0] obs_seg;
    obs_an  = {an_3, an_2, an_1, an_0};
    obs_seg = {g, f, e, d, c, b, a};
    vectors++;
    assert (obs_an === exp_an) else begin
      miscompares++;
      $error("FAIL %s anodes: got %b expected %b", tag, obs_an, exp_an);
    end
    vectors++;
    assert (obs_seg === exp_seg) else begin
      miscompares++;
      $error("FAIL %s segments gfedcba: got %b expected %b", tag, obs_seg, exp_seg);
    end
    vectors++;
    assert (dp === 1'b1) else begin
      miscompares++;
      $error("FAIL %s dp: got %b expected 1", tag, dp);
    end
    vectors++;
    assert ($countones(~obs_an) <= 1) else begin
      miscompares++;
      $error("FAIL %s onehot: got anodes %b expected at most one low", tag, obs_an);
    end
  endtask

  task automatic set_digits(input logic [3:0] d3, d2, d1, d0);
    digit_3 = d3; digit_2 = d2; digit_1 = d1; digit_0 = d0;
  endtask

  task automatic set_enables(input logic [3:0] en);
    {enable_3, enable_2, enable_1, enable_0} = en;
  endtask

  initial begin
    exp_tab[0]  = 7'b1000000;  exp_tab[1]  = 7'b1111001;
    exp_tab[2]  = 7'b0100100;  exp_tab[3]  = 7'b0110000;
    exp_tab[4]  = 7'b0011001;  exp_tab[5]  = 7'b0010010;
    exp_tab[6]  = 7'b0000010;  exp_tab[7]  = 7'b1111000;
    exp_tab[8]  = 7'b0000000;  exp_tab[9]  = 7'b0010000;
    exp_tab[10] = 7'b0001000;  exp_tab[11] = 7'b0000011;
    exp_tab[12] = 7'b1000110;  exp_tab[13] = 7'b0100001;
    exp_tab[14] = 7'b0000110;  exp_tab[15] = 7'b0001110;

    rst = 1'b1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    set_enables(4'b1111);

    // Reset held for two edges.
    step(); check("reset_edge1", 4'b1111, 7'b1111111);
    step(); check("reset_edge2", 4'b1111, 7'b1111111);

    // Scan after release: digit 0 first, period of four.
    rst = 1'b0;
    step(); check("scan_d0_4", 4'b1110, 7'b0011001);
    step(); check("scan_d1_3", 4'b1101, 7'b0110000);
    step(); check("scan_d2_2", 4'b1011, 7'b0100100);
    step(); check("scan_d3_1", 4'b0111, 7'b1111001);
    step(); check("scan_wrap_d0_4", 4'b1110, 7'b0011001);
    step(); check("scan_wrap_d1_3", 4'b1101, 7'b0110000);

    // Live update at idx=2.
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    step(); check("live_d2_6", 4'b1011, 7'b0000010);
    step(); check("live_d3_5", 4'b0111, 7'b0010010);
    step(); check("live_d0_8", 4'b1110, 7'b0000000);
    step(); check("live_d1_7", 4'b1101, 7'b1111000);

    // Enables: only digits 1 and 0 shown; idx is 2 here.
    set_digits(4'd0, 4'd0, 4'd9, 4'd0);
    set_enables(4'b0011);
    step(); check("en_d2_blank", 4'b1111, 7'b1111111);
    step(); check("en_d3_blank", 4'b1111, 7'b1111111);
    step(); check("en_d0_0", 4'b1110, 7'b1000000);
    step(); check("en_d1_9", 4'b1101, 7'b0010000);

    // Decode sweep on digit 0 only; finish the current scan first.
    set_enables(4'b0001);
    step(); check("sweep_pre_d2", 4'b1111, 7'b1111111);
    step(); check("sweep_pre_d3", 4'b1111, 7'b1111111);
    for (int v = 0; v < 16; v++) begin
      digit_0 = 4'(v);
      step(); check($sformatf("sweep_%h", v), 4'b1110, exp_tab[v]);
      step(); check($sformatf("sweep_%h_s1", v), 4'b1111, 7'b1111111);
      step(); check($sformatf("sweep_%h_s2", v), 4'b1111, 7'b1111111);
      step(); check($sformatf("sweep_%h_s3", v), 4'b1111, 7'b1111111);
    end

    // Mid-scan reset while idx=2, then restart from digit 0.
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    set_enables(4'b1111);
    step(); check("mid_d0_4", 4'b1110, 7'b0011001);
    step(); check("mid_d1_3", 4'b1101, 7'b0110000);
    rst = 1'b1;
    step(); check("mid_reset_blank", 4'b1111, 7'b1111111);
    rst = 1'b0;
    step(); check("mid_restart_d0_4", 4'b1110, 7'b0011001);
    step(); check("mid_restart_d1_3", 4'b1101, 7'b0110000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_display_driver

`default_nettype wire
